fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch stage of the RSA-decryption ASIP pipeline. Drives the IF stage's PC enable, `pc_selector` and `jmp_pc` inputs, and the IF/ID and ID/EX pipeline-register enable and flush lines. Arbitrates between start/restart, EX-stage redirects (taken branches and jumps), hazard-unit stalls and HALT decode. Sits between the hazard/branch-resolution logic and the `if_stage` instance.

---
 rtl/fetch_ctrl_pkg.sv | 14 +
 rtl/sat_counter.sv | 36 +++
 rtl/fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_fetch_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and widths for the instruction-fetch sequencing controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  localparam int FLUSH_CNT_W = 3;
  localparam int PERF_CNT_W  = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module sat_counter
  import fetch_ctrl_pkg::*;
#(
  parameter int W = PERF_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: start/redirect/halt/stall arbitration driving PC and IF/ID, ID/EX control.
// Optional stall/flush cycle counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               FLUSH_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall_req,
  input  logic             redirect_req,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             pc_selector,
  output logic [WIDTH-1:0] jmp_pc,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
`ifdef FETCH_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] flush_cycles,
`endif
  output logic             halted
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_DEPTH - 1);

  fetch_state_t           state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]       jmp_pc_q, jmp_pc_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    jmp_pc_d    = jmp_pc_q;
    pc_en       = 1'b0;
    pc_selector = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b1;
    id_ex_flush = 1'b1;
    halted      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          jmp_pc_d = RESET_PC;
          cnt_d    = FLUSH_LOAD;
          state_d  = ST_FLUSH;
        end
      end
      ST_RUN: begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (redirect_req) begin
          jmp_pc_d = redirect_pc;
          cnt_d    = FLUSH_LOAD;
          state_d  = ST_FLUSH;
        end else if (halt_req) begin
          state_d = ST_HALT;
        end else if (stall_req) begin
          // Combinational stall: freeze fetch and bubble EX in this very cycle
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      ST_FLUSH: begin
        if_id_en = 1'b1;
        // Counter still at its load value only in the first FLUSH cycle
        if (cnt_q == FLUSH_LOAD) begin
          pc_selector = 1'b1;
          pc_en       = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - FLUSH_CNT_W'(1);
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (start) begin
          jmp_pc_d = RESET_PC;
          cnt_d    = FLUSH_LOAD;
          state_d  = ST_FLUSH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      jmp_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      jmp_pc_q <= jmp_pc_d;
    end
  end

  assign jmp_pc = jmp_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic start_acc;
  logic stall_applied;
  logic flush_active;

  assign start_acc     = start && ((state_q == ST_IDLE) || (state_q == ST_HALT));
  assign stall_applied = (state_q == ST_RUN) && stall_req && !redirect_req && !halt_req;
  assign flush_active  = (state_q == ST_FLUSH);

  sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_acc),
    .inc   (stall_applied),
    .cnt   (stall_cycles)
  );

  sat_counter #(.W(PERF_CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_acc),
    .inc   (flush_active),
    .cnt   (flush_cycles)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Table-driven scoreboard bench for fetch_ctrl (default parameters, FLUSH_DEPTH = 2).
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stall_req = 1'b0;
  logic        redirect_req = 1'b0;
  logic        halt_req = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        pc_en, pc_selector, if_id_en, if_id_flush, id_ex_flush, halted;
  logic [31:0] jmp_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall_req    (stall_req),
    .redirect_req (redirect_req),
    .redirect_pc  (redirect_pc),
    .halt_req     (halt_req),
    .pc_en        (pc_en),
    .pc_selector  (pc_selector),
    .jmp_pc       (jmp_pc),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
`ifdef FETCH_PERF_CNT_EN
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles),
`endif
    .halted       (halted)
  );

  // Output patterns, bit order {pc_en, pc_selector, if_id_en, if_id_flush, id_ex_flush, halted}
  localparam logic [5:0] O_IDLE  = 6'b000110;
  localparam logic [5:0] O_F1    = 6'b111110;
  localparam logic [5:0] O_F2    = 6'b001110;
  localparam logic [5:0] O_RUN   = 6'b101000;
  localparam logic [5:0] O_STALL = 6'b000010;
  localparam logic [5:0] O_HALT  = 6'b000111;

  typedef struct {
    logic        start, stall, redir, halt;
    logic [31:0] rpc;
    logic [5:0]  outs;
    logic [31:0] jp;
    logic [31:0] sc;
    logic [31:0] fc;
  } vec_t;

  vec_t vecs[23];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Inputs bit order {start, stall, redirect, halt}
  function automatic vec_t mk(input logic [3:0] in, input logic [31:0] rpc, input logic [5:0] o,
                              input logic [31:0] jp, input logic [31:0] sc, input logic [31:0] fc);
    vec_t v;
    v.start = in[3];
    v.stall = in[2];
    v.redir = in[1];
    v.halt  = in[0];
    v.rpc   = rpc;
    v.outs  = o;
    v.jp    = jp;
    v.sc    = sc;
    v.fc    = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [5:0] o, input logic [31:0] jp,
                            input logic [31:0] sc, input logic [31:0] fc);
    chk({tag, " pc_en"},       {31'b0, pc_en},       {31'b0, o[5]});
    chk({tag, " pc_selector"}, {31'b0, pc_selector}, {31'b0, o[4]});
    chk({tag, " if_id_en"},    {31'b0, if_id_en},    {31'b0, o[3]});
    chk({tag, " if_id_flush"}, {31'b0, if_id_flush}, {31'b0, o[2]});
    chk({tag, " id_ex_flush"}, {31'b0, id_ex_flush}, {31'b0, o[1]});
    chk({tag, " halted"},      {31'b0, halted},      {31'b0, o[0]});
    chk({tag, " jmp_pc"},      jmp_pc,               jp);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, " stall_cycles"}, stall_cycles, sc);
    chk({tag, " flush_cycles"}, flush_cycles, fc);
`else
    if (sc == 32'hFFFF_FFFF || fc == 32'hFFFF_FFFF) $display("note: unexpected counter value");
`endif
  endtask

  initial begin
    vec_t e;
    vecs[0]  = mk(4'b0000, 32'h0,   O_IDLE,  32'h0,   0, 0);
    vecs[1]  = mk(4'b1000, 32'h0,   O_IDLE,  32'h0,   0, 0);
    vecs[2]  = mk(4'b0000, 32'h0,   O_F1,    32'h0,   0, 0);
    vecs[3]  = mk(4'b0000, 32'h0,   O_F2,    32'h0,   0, 1);
    vecs[4]  = mk(4'b0000, 32'h0,   O_RUN,   32'h0,   0, 2);
    vecs[5]  = mk(4'b0010, 32'h5C,  O_RUN,   32'h0,   0, 2);
    vecs[6]  = mk(4'b0000, 32'h0,   O_F1,    32'h5C,  0, 2);
    vecs[7]  = mk(4'b0100, 32'h0,   O_F2,    32'h5C,  0, 3);
    vecs[8]  = mk(4'b0100, 32'h0,   O_STALL, 32'h5C,  0, 4);
    vecs[9]  = mk(4'b0100, 32'h0,   O_STALL, 32'h5C,  1, 4);
    vecs[10] = mk(4'b0100, 32'h0,   O_STALL, 32'h5C,  2, 4);
    vecs[11] = mk(4'b0111, 32'h100, O_RUN,   32'h5C,  3, 4);
    vecs[12] = mk(4'b0000, 32'h0,   O_F1,    32'h100, 3, 4);
    vecs[13] = mk(4'b0001, 32'h0,   O_F2,    32'h100, 3, 5);
    vecs[14] = mk(4'b0001, 32'h0,   O_RUN,   32'h100, 3, 6);
    vecs[15] = mk(4'b0010, 32'h200, O_HALT,  32'h100, 3, 6);
    vecs[16] = mk(4'b0100, 32'h0,   O_HALT,  32'h100, 3, 6);
    vecs[17] = mk(4'b1000, 32'h0,   O_HALT,  32'h100, 3, 6);
    vecs[18] = mk(4'b0000, 32'h0,   O_F1,    32'h0,   0, 0);
    vecs[19] = mk(4'b0000, 32'h0,   O_F2,    32'h0,   0, 1);
    vecs[20] = mk(4'b0000, 32'h0,   O_RUN,   32'h0,   0, 2);
    vecs[21] = mk(4'b1000, 32'h0,   O_RUN,   32'h0,   0, 2);
    vecs[22] = mk(4'b0000, 32'h0,   O_RUN,   32'h0,   0, 2);

    repeat (2) @(negedge clk);
    #1;
    check_outs("reset", O_IDLE, 32'h0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 23; i++) begin
      start        = vecs[i].start;
      stall_req    = vecs[i].stall;
      redirect_req = vecs[i].redir;
      halt_req     = vecs[i].halt;
      redirect_pc  = vecs[i].rpc;
      exp_q.push_back(vecs[i]);
      #1;
      e = exp_q.pop_front();
      check_outs($sformatf("v%0d", i), e.outs, e.jp, e.sc, e.fc);
      $display("vec %0d: in=%b%b%b%b rpc=%h -> pc_en=%b sel=%b jmp=%h halted=%b",
               i, e.start, e.stall, e.redir, e.halt, e.rpc, pc_en, pc_selector, jmp_pc, halted);
      @(negedge clk);
    end
    start = 1'b0; stall_req = 1'b0; redirect_req = 1'b0; halt_req = 1'b0;

    // Stall response is purely combinational within one cycle
    #1;
    chk("pre-stall pc_en", {31'b0, pc_en}, 32'd1);
    stall_req = 1'b1;
    #1;
    chk("stall pc_en", {31'b0, pc_en}, 32'd0);
    chk("stall id_ex_flush", {31'b0, id_ex_flush}, 32'd1);
    stall_req = 1'b0;
    #1;
    chk("unstall pc_en", {31'b0, pc_en}, 32'd1);
    $display("seq stall: zero-latency stall toggle checked");
    @(negedge clk);

    // Asynchronous reset in the second FLUSH cycle
    redirect_req = 1'b1;
    redirect_pc  = 32'h5C;
    @(negedge clk);
    redirect_req = 1'b0;
    #1;
    chk("rst-seq f1 pc_selector", {31'b0, pc_selector}, 32'd1);
    chk("rst-seq f1 jmp_pc", jmp_pc, 32'h5C);
    @(negedge clk);
    #1;
    chk("rst-seq f2 pc_selector", {31'b0, pc_selector}, 32'd0);
    reset = 1'b0;
    #1;
    check_outs("async-reset", O_IDLE, 32'h0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_outs("post-reset idle", O_IDLE, 32'h0, 0, 0);
    @(negedge clk);
    #1;
    check_outs("post-reset idle2", O_IDLE, 32'h0, 0, 0);
    $display("seq reset: async reset mid-flush checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
